// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the gate truth-table sequencer and its reference model.
package gate_test_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_VECTORS = 8;

  function automatic logic is_legal_sel(input logic [2:0] sel);
    return sel <= 3'(GATE_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference truth table for the six 3-input gate types.
module gate_ref_model
  import gate_test_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic       expected_o
);

  logic andV;
  logic orV;
  logic xorV;

  // Illegal selections have no defined gate, so they report 0.
  always_comb begin
    andV       = a_i & b_i & c_i;
    orV        = a_i | b_i | c_i;
    xorV       = a_i ^ b_i ^ c_i;
    expected_o = 1'b0;
    case (gate_sel_e'(sel_i))
      GATE_AND:  expected_o = andV;
      GATE_OR:   expected_o = orV;
      GATE_NAND: expected_o = ~andV;
      GATE_NOR:  expected_o = ~orV;
      GATE_XOR:  expected_o = xorV;
      GATE_XNOR: expected_o = ~xorV;
      default:   expected_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_sequencer.sv
// Walks a 3-input gate through all eight input vectors, samples its output
// in the last hold cycle of each vector and accumulates a fail mask and error count.
module gate_truth_table_sequencer
  import gate_test_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [2:0] gate_sel_i,
  input  logic       d_i,
  output logic       a_o,
  output logic       b_o,
  output logic       c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       bad_sel_o,
  output logic [3:0] err_count_o,
  output logic [7:0] fail_mask_o
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [2:0] LAST_VEC  = 3'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] sel_q, sel_d;
  logic [3:0] errCount_q, errCount_d;
  logic [7:0] failMask_q, failMask_d;
  logic [2:0] abc_q, abc_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       badSel_q, badSel_d;

  logic       expected;
  logic       startAcc;
  logic       sampleNow;

  gate_ref_model uRef (
    .sel_i      (sel_q),
    .a_i        (vec_q[2]),
    .b_i        (vec_q[1]),
    .c_i        (vec_q[0]),
    .expected_o (expected)
  );

  assign startAcc  = start_i && (state_q == IDLE || state_q == DONE);
  assign sampleNow = (state_q == RUN) && (hold_q == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      vec_q      <= 3'd0;
      hold_q     <= 8'd0;
      sel_q      <= 3'd0;
      errCount_q <= 4'd0;
      failMask_q <= 8'd0;
      abc_q      <= 3'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      badSel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      sel_q      <= sel_d;
      errCount_q <= errCount_d;
      failMask_q <= failMask_d;
      abc_q      <= abc_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      badSel_q   <= badSel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    sel_d      = sel_q;
    errCount_d = errCount_q;
    failMask_d = failMask_q;
    case (state_q)
      IDLE, DONE: begin
        if (startAcc) begin
          sel_d      = gate_sel_i;
          errCount_d = 4'd0;
          failMask_d = 8'd0;
          vec_d      = 3'd0;
          hold_d     = 8'd0;
          state_d    = is_legal_sel(gate_sel_i) ? RUN : DONE;
        end
      end
      RUN: begin
        if (sampleNow) begin
          if (d_i != expected) begin
            failMask_d[vec_q] = 1'b1;
            errCount_d        = errCount_q + 4'd1;
          end
          hold_d = 8'd0;
          if (vec_q == LAST_VEC) begin
            state_d = DONE;
          end else begin
            vec_d = vec_q + 3'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Done-side flags lag entry into DONE by one edge and drop as soon as a restart is accepted.
  always_comb begin
    done_d   = (state_q == DONE) && !startAcc;
    badSel_d = done_d && !is_legal_sel(sel_d);
    pass_d   = done_d && (errCount_d == 4'd0) && is_legal_sel(sel_d);
    abc_d    = (state_d == RUN) ? vec_d : 3'd0;
  end

  assign {a_o, b_o, c_o} = abc_q;
  assign busy_o          = (state_q == RUN);
  assign done_o          = done_q;
  assign pass_o          = pass_q;
  assign bad_sel_o       = badSel_q;
  assign err_count_o     = errCount_q;
  assign fail_mask_o     = failMask_q;

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Self-checking bench: a behavioural gate under test with injectable faults,
// a table of runs with scoreboarded results, and hand-written corner sequences.
module tb_gate_truth_table_sequencer;
  import gate_test_pkg::*;

  localparam int HOLD = 4;

  typedef struct {
    logic [2:0] sel;
    int         mode;
    logic [3:0] err;
    logic [7:0] mask;
    logic       pass;
    logic       bad;
  } vec_t;

  typedef struct {
    logic [3:0] err;
    logic [7:0] mask;
    logic       pass;
    logic       bad;
  } result_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start;
  logic [2:0] gateSel;
  logic       d;
  logic       a, b, c;
  logic       busy, done, pass, badSel;
  logic [3:0] errCount;
  logic [7:0] failMask;

  logic [2:0] gutSel;
  int         gutMode;

  logic [2:0] refSel;
  logic       refA, refB, refC, refY;

  int      vectorsApplied = 0;
  int      miscompares    = 0;
  result_t sbQueue[$];
  vec_t    table_q[11];

  always #5 clk = ~clk;

  gate_truth_table_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk_i       (clk),
    .rst_n_i     (rstN),
    .start_i     (start),
    .gate_sel_i  (gateSel),
    .d_i         (d),
    .a_o         (a),
    .b_o         (b),
    .c_o         (c),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .bad_sel_o   (badSel),
    .err_count_o (errCount),
    .fail_mask_o (failMask)
  );

  gate_ref_model uRefCheck (
    .sel_i      (refSel),
    .a_i        (refA),
    .b_i        (refB),
    .c_i        (refC),
    .expected_o (refY)
  );

  function automatic logic refTruth(input logic [2:0] s, input logic [2:0] v);
    logic x, y, z;
    x = v[2];
    y = v[1];
    z = v[0];
    case (s)
      3'd0:    return x & y & z;
      3'd1:    return x | y | z;
      3'd2:    return !(x && y && z);
      3'd3:    return !(x || y || z);
      3'd4:    return (x + y + z) % 2 == 1;
      3'd5:    return (x + y + z) % 2 == 0;
      default: return 1'b0;
    endcase
  endfunction

  // Mode 0 healthy, 1 stuck-at-0, 2 inverted, 3 stuck-at-1, 4 wrong only on vector 3.
  function automatic logic gutOut(input logic [2:0] s, input int mode, input logic [2:0] v);
    logic t;
    t = refTruth(s, v);
    case (mode)
      1:       return 1'b0;
      2:       return !t;
      3:       return 1'b1;
      4:       return (v == 3'd3) ? !t : t;
      default: return t;
    endcase
  endfunction

  always_comb d = gutOut(gutSel, gutMode, {a, b, c});

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t t, input int abortAt, input bit disturb);
    result_t exp;
    result_t got;
    int      doneCycle;
    int      busyCycles;
    bit      aborted;
    bit      legal;
    doneCycle  = -1;
    busyCycles = 0;
    aborted    = 1'b0;
    legal      = (t.sel <= 3'd5);
    gateSel    = t.sel;
    gutSel     = t.sel;
    gutMode    = t.mode;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    exp.err  = t.err;
    exp.mask = t.mask;
    exp.pass = t.pass;
    exp.bad  = t.bad;
    sbQueue.push_back(exp);
    for (int j = 0; j <= 8 * HOLD + 10; j++) begin
      if (j == abortAt) begin
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("resetMidRun",
                    32'({busy, done, pass, badSel, errCount, failMask, a, b, c}), 32'd0);
        rstN = 1'b1;
        sbQueue.delete();
        aborted = 1'b1;
        break;
      end
      if (disturb && j == 13) begin
        start   = 1'b1;
        gateSel = 3'd3;
      end
      if (disturb && j == 14) start = 1'b0;
      if (busy) busyCycles++;
      if (busy && (j % HOLD) == HOLD - 1) checkOutput("abcStep", 32'({a, b, c}), 32'(j / HOLD));
      if (done) begin
        doneCycle = j;
        break;
      end
      @(negedge clk);
    end
    if (!aborted) begin
      checkOutput("doneLatency", 32'(doneCycle), legal ? 32'(8 * HOLD + 1) : 32'd1);
      checkOutput("busyCycles", 32'(busyCycles), legal ? 32'(8 * HOLD) : 32'd0);
      checkOutput("abcInDone", 32'({a, b, c}), 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("scoreboardEmpty", 32'd0, 32'd1);
      end else begin
        got = sbQueue.pop_front();
        checkOutput("errCount", 32'(errCount), 32'(got.err));
        checkOutput("failMask", 32'(failMask), 32'(got.mask));
        checkOutput("pass", 32'(pass), 32'(got.pass));
        checkOutput("badSel", 32'(badSel), 32'(got.bad));
      end
    end
  endtask

  initial begin
    vec_t hand;
    rstN    = 1'b0;
    start   = 1'b0;
    gateSel = 3'd0;
    gutSel  = 3'd0;
    gutMode = 0;
    refSel  = 3'd0;
    refA    = 1'b0;
    refB    = 1'b0;
    refC    = 1'b0;

    table_q[0]  = '{3'd0, 0, 4'd0, 8'h00, 1'b1, 1'b0};
    table_q[1]  = '{3'd1, 1, 4'd7, 8'hFE, 1'b0, 1'b0};
    table_q[2]  = '{3'd4, 2, 4'd8, 8'hFF, 1'b0, 1'b0};
    table_q[3]  = '{3'd2, 0, 4'd0, 8'h00, 1'b1, 1'b0};
    table_q[4]  = '{3'd3, 1, 4'd1, 8'h01, 1'b0, 1'b0};
    table_q[5]  = '{3'd5, 0, 4'd0, 8'h00, 1'b1, 1'b0};
    table_q[6]  = '{3'd0, 3, 4'd7, 8'h7F, 1'b0, 1'b0};
    table_q[7]  = '{3'd4, 4, 4'd1, 8'h08, 1'b0, 1'b0};
    table_q[8]  = '{3'd6, 0, 4'd0, 8'h00, 1'b0, 1'b1};
    table_q[9]  = '{3'd7, 0, 4'd0, 8'h00, 1'b0, 1'b1};
    table_q[10] = '{3'd1, 0, 4'd0, 8'h00, 1'b1, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("resetState",
                32'({busy, done, pass, badSel, errCount, failMask, a, b, c}), 32'd0);
    rstN = 1'b1;

    for (int s = 0; s < 8; s++) begin
      for (int v = 0; v < 8; v++) begin
        refSel             = 3'(s);
        {refA, refB, refC} = 3'(v);
        #1;
        checkOutput("refModel", 32'(refY), 32'(refTruth(3'(s), 3'(v))));
      end
    end

    for (int i = 0; i < 11; i++) applyStimulus(table_q[i], -1, 1'b0);

    // Restart pulse and sel change in the middle of vector 3 must not disturb the run.
    hand = '{3'd0, 0, 4'd0, 8'h00, 1'b1, 1'b0};
    applyStimulus(hand, -1, 1'b1);

    hand = '{3'd1, 1, 4'd7, 8'hFE, 1'b0, 1'b0};
    applyStimulus(hand, 5 * HOLD + 1, 1'b0);

    @(negedge clk);
    start = 1'b1;
    rstN  = 1'b0;
    @(negedge clk);
    checkOutput("resetBeatsStart", 32'({busy, done}), 32'd0);
    start = 1'b0;
    rstN  = 1'b1;
    @(negedge clk);
    checkOutput("idleAfterReset", 32'(busy), 32'd0);

    hand = '{3'd0, 0, 4'd0, 8'h00, 1'b1, 1'b0};
    applyStimulus(hand, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
